// File: rtl/one_addr_rr_arb.sv
// Round-robin arbiter: rotating-pointer scan, held one-hot grant plus index; 1-cycle req->gnt latency.
// Grant held until rel or owner drop, then a mandatory 1-cycle bubble; optional revoke via ARB_TIMEOUT_EN.
module one_addr_rr_arb #(
  parameter int N     = 5,
  parameter int WIDTH = $clog2(N),
  parameter int TMO   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             rel,
  output logic [N-1:0]     gnt,
  output logic [WIDTH-1:0] gnt_addr,
  output logic             gnt_vld,
  output logic             tmo_o
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_ptr;
  logic [N-1:0]     r_gnt;
  logic [WIDTH-1:0] r_gnt_addr;
  logic             r_gnt_vld;

  logic [WIDTH-1:0] w_ptr_nxt;
  logic [N-1:0]     w_gnt_nxt;
  logic [WIDTH-1:0] w_gnt_addr_nxt;
  logic             w_gnt_vld_nxt;

  logic             w_pick_vld;
  logic [WIDTH-1:0] w_pick;
  logic             w_rel_evt;
  logic             w_tmo_hit;
  logic [WIDTH-1:0] w_ptr_inc;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_tmo;
  logic          w_tmo_nxt;

  assign w_tmo_hit = (r_cnt == CW'(TMO - 1));
  assign tmo_o     = r_tmo;
`else
  assign w_tmo_hit = 1'b0;
  assign tmo_o     = 1'b0;
`endif

  // Descending scan so the candidate closest to the pointer is written last and wins.
  always_comb begin
    logic [WIDTH-1:0] idx;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    idx        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = WIDTH'((int'(r_ptr) + k) % N);
      if (|(req & (N'(1) << idx))) begin
        w_pick_vld = 1'b1;
        w_pick     = idx;
      end
    end
  end

  // A dropped owner request is treated the same as an explicit release.
  assign w_rel_evt = rel | ~(|(req & r_gnt));
  assign w_ptr_inc = (r_gnt_addr == WIDTH'(N - 1)) ? '0 : r_gnt_addr + WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_vld) w_state_nxt = S_GRANT;
      S_GRANT: if (w_rel_evt || w_tmo_hit) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ptr_nxt      = r_ptr;
    w_gnt_nxt      = '0;
    w_gnt_addr_nxt = '0;
    w_gnt_vld_nxt  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_cnt_nxt      = '0;
    w_tmo_nxt      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt      = N'(1) << w_pick;
          w_gnt_addr_nxt = w_pick;
          w_gnt_vld_nxt  = 1'b1;
        end
      end
      S_GRANT: begin
        if (w_rel_evt || w_tmo_hit) begin
          w_ptr_nxt = w_ptr_inc;
`ifdef ARB_TIMEOUT_EN
          w_tmo_nxt = w_tmo_hit & ~w_rel_evt;
`endif
        end else begin
          w_gnt_nxt      = r_gnt;
          w_gnt_addr_nxt = r_gnt_addr;
          w_gnt_vld_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_cnt_nxt      = r_cnt + CW'(1);
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_gnt_addr <= '0;
      r_gnt_vld  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_cnt      <= '0;
      r_tmo      <= 1'b0;
`endif
    end else begin
      r_ptr      <= w_ptr_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_addr <= w_gnt_addr_nxt;
      r_gnt_vld  <= w_gnt_vld_nxt;
`ifdef ARB_TIMEOUT_EN
      r_cnt      <= w_cnt_nxt;
      r_tmo      <= w_tmo_nxt;
`endif
    end
  end

  assign gnt      = r_gnt;
  assign gnt_addr = r_gnt_addr;
  assign gnt_vld  = r_gnt_vld;

endmodule
